// File: rtl/regfile_write_arbiter.sv
// Writeback arbiter for the register file's single write port: ALU results win by default,
// load results queue in a small FIFO and are force-granted once the queue head has waited too long.
module regfile_write_arbiter #(
  parameter int DATA_WIDTH    = 32,
  parameter int REG_NUM_WIDTH = 5,
  parameter int LQ_DEPTH      = 4,
  parameter int STARVE_LIMIT  = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          alu_valid,
  output logic                          alu_ready,
  input  logic [REG_NUM_WIDTH-1:0]      alu_reg,
  input  logic [DATA_WIDTH-1:0]         alu_data,
  input  logic                          ld_valid,
  output logic                          ld_ready,
  input  logic [REG_NUM_WIDTH-1:0]      ld_reg,
  input  logic [DATA_WIDTH-1:0]         ld_data,
  output logic                          wrEnable,
  output logic [REG_NUM_WIDTH-1:0]      wrNum,
  output logic [DATA_WIDTH-1:0]         wrData,
  output logic [$clog2(LQ_DEPTH):0]     ld_q_count
);

  localparam int PTR_W = $clog2(LQ_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int AGE_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [AGE_W-1:0] AGE_MAX   = AGE_W'(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(LQ_DEPTH);

  logic [REG_NUM_WIDTH-1:0] q_reg  [LQ_DEPTH];
  logic [DATA_WIDTH-1:0]    q_data [LQ_DEPTH];
  logic [PTR_W-1:0]         rd_ptr;
  logic [PTR_W-1:0]         wr_ptr;
  logic [AGE_W-1:0]         age;

  logic q_empty;
  logic q_full;
  logic force_grant;
  logic grant_alu;
  logic grant_load;
  logic push;
  logic pop;

  // Grant decision; force and the ready outputs depend only on registered state and rst.
  always_comb begin
    q_empty     = (ld_q_count == '0);
    q_full      = (ld_q_count == CNT_FULL);
    force_grant = !q_empty && (age >= AGE_MAX);
    alu_ready   = !rst && !force_grant;
    ld_ready    = !rst && !q_full;
    grant_alu   = alu_valid && alu_ready;
    grant_load  = !rst && !q_empty && (force_grant || !alu_valid);
    push        = ld_valid && ld_ready;
    pop         = grant_load;
  end

  // NOTE: the FIFO payload array has no reset; occupancy and pointers alone decide what is valid,
  // so clearing the storage would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (push) begin
      q_reg[wr_ptr]  <= ld_reg;
      q_data[wr_ptr] <= ld_data;
    end
  end

  // NOTE: all state below uses non-blocking assignments so every register sees the
  // pre-edge values of its neighbours regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      ld_q_count <= '0;
      age        <= '0;
      wrEnable   <= 1'b0;
      wrNum      <= '0;
      wrData     <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);

      case ({push, pop})
        2'b10:   ld_q_count <= ld_q_count + CNT_W'(1);
        2'b01:   ld_q_count <= ld_q_count - CNT_W'(1);
        default: ld_q_count <= ld_q_count;
      endcase

      // Age tracks how long the current head has been waiting; a new head starts from zero.
      if (pop || q_empty)      age <= '0;
      else if (age != AGE_MAX) age <= age + AGE_W'(1);

      if (grant_alu) begin
        wrEnable <= 1'b1;
        wrNum    <= alu_reg;
        wrData   <= alu_data;
      end else if (grant_load) begin
        wrEnable <= 1'b1;
        wrNum    <= q_reg[rd_ptr];
        wrData   <= q_data[rd_ptr];
      end else begin
        wrEnable <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: directed steps plus random traffic compared
// cycle by cycle against a queue-based reference model of the writeback rules.
module tb_regfile_write_arbiter;

  localparam int DW    = 32;
  localparam int RW    = 5;
  localparam int DEPTH = 4;
  localparam int LIMIT = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          alu_valid, alu_ready, ld_valid, ld_ready;
  logic [RW-1:0] alu_reg, ld_reg, wr_num;
  logic [DW-1:0] alu_data, ld_data, wr_data;
  logic          wr_enable;
  logic [2:0]    ld_q_count;

  logic          b_alu_valid, b_alu_ready, b_ld_valid, b_ld_ready;
  logic [RW-1:0] b_alu_reg, b_ld_reg, b_wr_num;
  logic [DW-1:0] b_alu_data, b_ld_data, b_wr_data;
  logic          b_wr_enable;
  logic [2:0]    b_ld_q_count;

  always #5 clk = ~clk;

  regfile_write_arbiter #(.DATA_WIDTH(DW), .REG_NUM_WIDTH(RW), .LQ_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_reg(alu_reg), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_reg(ld_reg), .ld_data(ld_data),
    .wrEnable(wr_enable), .wrNum(wr_num), .wrData(wr_data), .ld_q_count(ld_q_count)
  );

  // Second instance with a long starvation limit, used for the fill-and-block scenario.
  regfile_write_arbiter #(.DATA_WIDTH(DW), .REG_NUM_WIDTH(RW), .LQ_DEPTH(DEPTH), .STARVE_LIMIT(8)) dut_b (
    .clk(clk), .rst(rst),
    .alu_valid(b_alu_valid), .alu_ready(b_alu_ready), .alu_reg(b_alu_reg), .alu_data(b_alu_data),
    .ld_valid(b_ld_valid), .ld_ready(b_ld_ready), .ld_reg(b_ld_reg), .ld_data(b_ld_data),
    .wrEnable(b_wr_enable), .wrNum(b_wr_num), .wrData(b_wr_data), .ld_q_count(b_ld_q_count)
  );

  typedef struct packed {
    logic [RW-1:0] r;
    logic [DW-1:0] d;
  } ld_t;

  // Reference model: pending loads in arrival order, head wait time, last write-port contents.
  ld_t           mq[$];
  int            m_age;
  logic          m_we;
  logic [RW-1:0] m_num;
  logic [DW-1:0] m_data;

  int vectors     = 0;
  int miscompares = 0;
  bit last_alu_acc = 1'b0;
  bit last_ld_acc  = 1'b0;
  int seen_at;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: check readies against the model, advance the model, then check the outputs.
  task automatic tick();
    bit frc, exp_ar, exp_lr, alu_acc, ld_acc, popped, was_empty;
    frc = 0; exp_ar = 0; exp_lr = 0; alu_acc = 0; ld_acc = 0; popped = 0; was_empty = 0;
    #1;
    if (!rst) begin
      frc    = (mq.size() != 0) && (m_age >= LIMIT);
      exp_ar = !frc;
      exp_lr = mq.size() < DEPTH;
    end
    check("alu_ready", {63'd0, alu_ready}, {63'd0, exp_ar});
    check("ld_ready",  {63'd0, ld_ready},  {63'd0, exp_lr});
    if (rst) begin
      mq.delete();
      m_age = 0; m_we = 0; m_num = '0; m_data = '0;
    end else begin
      alu_acc   = alu_valid && exp_ar;
      ld_acc    = ld_valid && exp_lr;
      was_empty = (mq.size() == 0);
      if (alu_acc) begin
        m_we = 1; m_num = alu_reg; m_data = alu_data;
      end else if (!was_empty && (frc || !alu_valid)) begin
        m_we = 1; m_num = mq[0].r; m_data = mq[0].d;
        void'(mq.pop_front());
        popped = 1;
      end else begin
        m_we = 0;
      end
      if (popped || was_empty) m_age = 0;
      else if (m_age < LIMIT)  m_age++;
      if (ld_acc) mq.push_back(ld_t'{r: ld_reg, d: ld_data});
    end
    last_alu_acc = alu_acc;
    last_ld_acc  = ld_acc;
    @(posedge clk);
    #1;
    check("wrEnable",   {63'd0, wr_enable}, {63'd0, m_we});
    check("wrNum",      {59'd0, wr_num},    {59'd0, m_num});
    check("wrData",     {32'd0, wr_data},   {32'd0, m_data});
    check("ld_q_count", {61'd0, ld_q_count}, 64'(mq.size()));
  endtask

  initial begin
    rst = 1'b1;
    alu_valid = 0; alu_reg = '0; alu_data = '0;
    ld_valid = 0;  ld_reg = '0;  ld_data = '0;
    b_alu_valid = 0; b_alu_reg = '0; b_alu_data = '0;
    b_ld_valid = 0;  b_ld_reg = '0;  b_ld_data = '0;
    m_age = 0; m_we = 0; m_num = '0; m_data = '0;

    // Reset state and ALU latency
    tick();
    tick();
    check("rst_wrEnable", {63'd0, wr_enable}, 64'd0);
    check("rst_count", {61'd0, ld_q_count}, 64'd0);
    rst = 1'b0;
    alu_valid = 1; alu_reg = 5'd3; alu_data = 32'h11;
    tick();
    check("alu_first_num", {59'd0, wr_num}, 64'd3);
    check("alu_first_data", {32'd0, wr_data}, 64'h11);

    // Load only: count 1 after one edge, written on the next
    alu_valid = 0;
    ld_valid = 1; ld_reg = 5'd7; ld_data = 32'hAB;
    tick();
    check("load_count1", {61'd0, ld_q_count}, 64'd1);
    check("load_no_bypass", {63'd0, wr_enable}, 64'd0);
    ld_valid = 0;
    tick();
    check("load_write_num", {59'd0, wr_num}, 64'd7);
    check("load_write_data", {32'd0, wr_data}, 64'hAB);
    check("load_count0", {61'd0, ld_q_count}, 64'd0);

    // Fill and block on the long-limit instance
    for (int i = 0; i < 5; i++) begin
      b_alu_valid = 1; b_alu_reg = 5'd1; b_alu_data = 32'(i);
      b_ld_valid = 1; b_ld_reg = 5'(20 + i); b_ld_data = 32'h100 + 32'(i);
      #1;
      check("fill_ld_ready", {63'd0, b_ld_ready}, (i < 4) ? 64'd1 : 64'd0);
      tick();
      check("fill_alu_num", {59'd0, b_wr_num}, 64'd1);
      check("fill_alu_data", {32'd0, b_wr_data}, 64'(i));
    end
    check("fill_count", {61'd0, b_ld_q_count}, 64'd4);
    b_alu_valid = 0; b_ld_valid = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("drain_en", {63'd0, b_wr_enable}, 64'd1);
      check("drain_num", {59'd0, b_wr_num}, 64'(20 + k));
      check("drain_data", {32'd0, b_wr_data}, 64'h100 + 64'(k));
    end
    tick();
    check("drain_idle", {63'd0, b_wr_enable}, 64'd0);
    check("drain_count", {61'd0, b_ld_q_count}, 64'd0);

    // Starvation: one queued load under a continuous ALU stream
    seen_at = -1;
    alu_valid = 1; alu_reg = 5'd10; alu_data = 32'h2000;
    last_alu_acc = 1'b0;
    for (int s = 0; s < 8; s++) begin
      if (last_alu_acc) begin
        alu_reg = 5'(10 + s); alu_data = 32'h2000 + 32'(s);
      end
      ld_valid = (s == 0); ld_reg = 5'd9; ld_data = 32'h55;
      tick();
      if (wr_enable && wr_num == 5'd9 && wr_data == 32'h55) seen_at = s;
    end
    check("starve_write_cycle", 64'(seen_at), 64'd4);

    // Simultaneous push and pop at count 2
    alu_valid = 1; alu_reg = 5'd4; alu_data = 32'h4444;
    for (int p = 0; p < 2; p++) begin
      ld_valid = 1; ld_reg = 5'(12 + p); ld_data = 32'h1200 + 32'(p);
      tick();
    end
    alu_valid = 0;
    ld_valid = 1; ld_reg = 5'd14; ld_data = 32'h1202;
    tick();
    check("pushpop_count", {61'd0, ld_q_count}, 64'd2);

    // Random mix; upstream holds payloads until accepted
    for (int i = 0; i < 20; i++) begin
      if (!(alu_valid && !last_alu_acc)) begin
        alu_valid = 1'($urandom_range(0, 1)); alu_reg = 5'($urandom); alu_data = $urandom;
      end
      if (!(ld_valid && !last_ld_acc)) begin
        ld_valid = 1'($urandom_range(0, 1)); ld_reg = 5'($urandom); ld_data = $urandom;
      end
      tick();
    end
    alu_valid = 0; ld_valid = 0;
    for (int i = 0; i < 8; i++) tick();
    check("random_drained", {61'd0, ld_q_count}, 64'd0);

    // Reset with three loads queued discards them
    alu_valid = 1; alu_reg = 5'd2; alu_data = 32'h2222;
    for (int p = 0; p < 3; p++) begin
      ld_valid = 1; ld_reg = 5'(28 + p); ld_data = 32'hDEAD0000 + 32'(p);
      tick();
    end
    check("pre_rst_count", {61'd0, ld_q_count}, 64'd3);
    ld_valid = 0;
    rst = 1'b1;
    tick();
    check("mid_rst_count", {61'd0, ld_q_count}, 64'd0);
    check("mid_rst_wrEnable", {63'd0, wr_enable}, 64'd0);
    rst = 1'b0;
    alu_valid = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("post_rst_idle", {63'd0, wr_enable}, 64'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
